// File: rtl/z_core_pkg.sv
// Shared encodings for the Z-Core control path: opcodes, FSM states and
// datapath select values, plus the instruction legality check.
package z_core_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] FENCE  = 7'b0001111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK,
        S_TRAP
    } state_t;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'b00,
        PC_IMM   = 2'b01,
        PC_JALR  = 2'b10
    } pc_src_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_ECALL   = 2'b10,
        CAUSE_BUS     = 2'b11
    } trap_cause_t;

    // Unknown opcodes and reserved funct3 values of known opcodes are illegal.
    function automatic logic is_illegal(input logic [6:0] opc, input logic [2:0] f3);
        logic ill;
        case (opc)
            OP, OP_IMM, LUI, AUIPC, JAL, FENCE, SYSTEM: ill = 1'b0;
            JALR:    ill = (f3 != 3'b000);
            BRANCH:  ill = (f3 == 3'b010) || (f3 == 3'b011);
            LOAD:    ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            STORE:   ill = (f3 >= 3'b011);
            default: ill = 1'b1;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/z_core_mem_watchdog.sv
// Counts consecutive stalled memory-request cycles and flags a bus timeout
// on the MEM_TIMEOUT-th stalled cycle; MEM_TIMEOUT = 0 disables it.
module z_core_mem_watchdog
#(
    parameter int unsigned MEM_TIMEOUT = 255
)
(
    input  logic clk,
    input  logic rstn,
    input  logic mem_req,
    input  logic mem_ready,
    output logic timeout
);

    localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

    logic [CW-1:0] count;
    logic          waiting;

    assign waiting = mem_req && !mem_ready;

    // count holds the number of earlier stalled cycles, so the limit is hit
    // combinationally in the stalled cycle itself and mem_ready can still win.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (!waiting) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    assign timeout = (MEM_TIMEOUT != 0) && waiting && (count == LIMIT);

endmodule

// File: rtl/z_core_control_unit.sv
// Multi-cycle control FSM for the Z-Core RV32I datapath: sequences
// fetch/decode/execute/memory/writeback and traps on faults.
module z_core_control_unit
    import z_core_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
)
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_sel_data,
    output logic       ir_load,
    output logic       rf_we,
    output logic       pc_load,
    output logic [1:0] pc_src,
    output logic [1:0] wb_sel,
    output logic       alu_a_sel,
    output logic       alu_b_sel,
    output logic [2:0] imm_sel,
    output logic       retire,
    output logic       trap,
    output logic [1:0] trap_cause
);

    state_t      state;
    trap_cause_t cause;
    logic        illegal;
    logic        timeout;
    logic        in_instr;

    assign illegal = is_illegal(op, funct3);

    z_core_mem_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_watchdog (
        .clk       (clk),
        .rstn      (rstn),
        .mem_req   (mem_req),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
            cause <= CAUSE_NONE;
        end else begin
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (timeout) begin
                        state <= S_TRAP;
                        cause <= CAUSE_BUS;
                    end else if (mem_ready) begin
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (illegal) begin
                        state <= S_TRAP;
                        cause <= CAUSE_ILLEGAL;
                    end else if (op == SYSTEM) begin
                        state <= S_TRAP;
                        cause <= CAUSE_ECALL;
                    end else begin
                        state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (op == BRANCH || op == FENCE) begin
                        state <= S_FETCH;
                    end else if (op == LOAD || op == STORE) begin
                        state <= S_MEM;
                    end else begin
                        state <= S_WRITEBACK;
                    end
                end
                S_MEM: begin
                    if (timeout) begin
                        state <= S_TRAP;
                        cause <= CAUSE_BUS;
                    end else if (mem_ready) begin
                        state <= (op == LOAD) ? S_WRITEBACK : S_FETCH;
                    end
                end
                S_WRITEBACK: state <= S_FETCH;
                S_TRAP:      state <= S_TRAP;
                default:     state <= S_IDLE;
            endcase
        end
    end

    assign in_instr = (state == S_DECODE) || (state == S_EXECUTE) ||
                      (state == S_MEM) || (state == S_WRITEBACK);

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_sel_data = 1'b0;
        ir_load      = 1'b0;
        rf_we        = 1'b0;
        pc_load      = 1'b0;
        pc_src       = PC_PLUS4;
        wb_sel       = WB_ALU;
        alu_a_sel    = 1'b0;
        alu_b_sel    = 1'b0;
        imm_sel      = IMM_I;
        retire       = 1'b0;

        // Operand selects stay valid from DECODE until the instruction leaves.
        if (in_instr && !illegal) begin
            case (op)
                OP_IMM, LOAD: alu_b_sel = 1'b1;
                STORE: begin
                    imm_sel   = IMM_S;
                    alu_b_sel = 1'b1;
                end
                BRANCH: imm_sel = IMM_B;
                LUI:    imm_sel = IMM_U;
                AUIPC: begin
                    imm_sel   = IMM_U;
                    alu_a_sel = 1'b1;
                end
                JAL: begin
                    imm_sel   = IMM_J;
                    alu_a_sel = 1'b1;
                end
                default: ;
            endcase
        end

        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_load = mem_ready;
            end
            S_EXECUTE: begin
                if (op == BRANCH) begin
                    pc_load = 1'b1;
                    pc_src  = branch_taken ? PC_IMM : PC_PLUS4;
                    retire  = 1'b1;
                end else if (op == FENCE) begin
                    pc_load = 1'b1;
                    retire  = 1'b1;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_sel_data = 1'b1;
                mem_we       = (op == STORE);
                if (op == STORE && mem_ready) begin
                    pc_load = 1'b1;
                    retire  = 1'b1;
                end
            end
            S_WRITEBACK: begin
                rf_we   = 1'b1;
                pc_load = 1'b1;
                retire  = 1'b1;
                if (op == LOAD) begin
                    wb_sel = WB_MEM;
                end else if (op == JAL || op == JALR) begin
                    wb_sel = WB_PC4;
                end
                if (op == JAL) begin
                    pc_src = PC_IMM;
                end else if (op == JALR) begin
                    pc_src = PC_JALR;
                end
            end
            default: ;
        endcase
    end

    assign trap       = (state == S_TRAP);
    assign trap_cause = cause;

endmodule
